// File: rtl/bobina_troca_ctrl.sv
// ----------------------------------------------------------------------------
// bobina_troca_ctrl
//
// Sequencing controller for the paper-roll changeover (splice) station.
// It watches the new-roll, speed-match and roll-empty sensors. It then runs
// the accelerate -> glue -> cut sequence with timed phases, raises an alarm
// on faults, and counts completed changeovers and fault entries.
//
// All outputs are registered together with the state register. They change
// on the same clk_2 edge as estado, and no combinational path runs from a
// sensor to an actuator.
//
// Parameters
//   T_ACEL_MAX  cycles allowed in ACELERANDO waiting for velocidade
//   T_COLA      cycles colar is held (glue phase length)
//   T_CORTE     cycles cortar is held (cut phase length)
//   NBITS_CNT   width of the trocas / erros counters
//
// Ports
//   clk_2       in   system clock, all state on posedge
//   reset       in   asynchronous, active-low reset
//   nova        in   new roll loaded and ready to splice
//   velocidade  in   new roll surface speed matched to web speed
//   vazio       in   running roll empty
//   ack         in   operator alarm acknowledge
//   acelerar    out  accelerate new roll
//   colar       out  fire glue/splice head
//   cortar      out  fire cutter on old web
//   alarme      out  fault indicator
//   estado      out  current state code (LCD/LED debug)
//   trocas      out  completed changeovers, saturating
//   erros       out  fault entries, saturating
// ----------------------------------------------------------------------------
module bobina_troca_ctrl #(
    parameter int T_ACEL_MAX = 16,
    parameter int T_COLA     = 4,
    parameter int T_CORTE    = 2,
    parameter int NBITS_CNT  = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 nova,
    input  logic                 velocidade,
    input  logic                 vazio,
    input  logic                 ack,
    output logic                 acelerar,
    output logic                 colar,
    output logic                 cortar,
    output logic                 alarme,
    output logic [2:0]           estado,
    output logic [NBITS_CNT-1:0] trocas,
    output logic [NBITS_CNT-1:0] erros
);

    // ------------------------------------------------------------------------
    // State codes (fixed: they are shown on the debug display)
    // ------------------------------------------------------------------------
    localparam logic [2:0] STAND_BY       = 3'd0;
    localparam logic [2:0] ERRO           = 3'd1;
    localparam logic [2:0] ACELERANDO     = 3'd2;
    localparam logic [2:0] COLANDO        = 3'd3;
    localparam logic [2:0] CORTANDO       = 3'd4;
    localparam logic [2:0] TROCA_EFETUADA = 3'd5;

    // The phase counter must reach the longest timed phase's final value.
    localparam int CNT_MAX_PHASE = (T_ACEL_MAX > T_COLA)
                                   ? ((T_ACEL_MAX > T_CORTE) ? T_ACEL_MAX : T_CORTE)
                                   : ((T_COLA > T_CORTE) ? T_COLA : T_CORTE);
    localparam int CW = $clog2(CNT_MAX_PHASE + 1);

    localparam logic [CW-1:0] ACEL_LAST  = CW'(T_ACEL_MAX - 1);
    localparam logic [CW-1:0] COLA_LAST  = CW'(T_COLA - 1);
    localparam logic [CW-1:0] CORTE_LAST = CW'(T_CORTE - 1);

    localparam logic [NBITS_CNT-1:0] CNT_SAT = {NBITS_CNT{1'b1}};

    logic [2:0]    next_estado;
    logic [CW-1:0] cnt;
    logic          timed_state;
    logic          entering_troca;
    logic          entering_erro;

    // Outputs decoded from next_estado, so they are registered with it.
    logic next_acelerar;
    logic next_colar;
    logic next_cortar;
    logic next_alarme;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first, so every path drives next_estado and no latch is inferred.
        next_estado = estado;
        case (estado)
            STAND_BY: begin
                // A loaded roll takes priority over an empty running roll.
                if (nova)
                    next_estado = ACELERANDO;
                else if (vazio)
                    next_estado = ERRO;
            end
            ACELERANDO: begin
                // Speed match wins over both the empty sensor and the timeout.
                if (velocidade)
                    next_estado = COLANDO;
                else if (vazio || (cnt == ACEL_LAST))
                    next_estado = ERRO;
                else if (!nova)
                    next_estado = STAND_BY;
            end
            COLANDO: begin
                // Losing speed match while gluing would tear the web.
                if (!velocidade)
                    next_estado = ERRO;
                else if (cnt == COLA_LAST)
                    next_estado = CORTANDO;
            end
            CORTANDO: begin
                // Sensors are ignored here: a cut in progress always completes.
                if (cnt == CORTE_LAST)
                    next_estado = TROCA_EFETUADA;
            end
            TROCA_EFETUADA: begin
                // Hold while nova stays high, so one load gives one changeover.
                if (!nova)
                    next_estado = STAND_BY;
            end
            ERRO: begin
                // Leave only when the operator acknowledges a clean station.
                if (ack && !vazio && !nova)
                    next_estado = STAND_BY;
            end
            default: begin
                // Codes 6 and 7 are unreachable. Treat them as a fault.
                next_estado = ERRO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode for the state being entered
    // ------------------------------------------------------------------------
    always_comb begin
        next_acelerar = 1'b0;
        next_colar    = 1'b0;
        next_cortar   = 1'b0;
        next_alarme   = 1'b0;
        case (next_estado)
            ACELERANDO: next_acelerar = 1'b1;
            COLANDO: begin
                // Keep the new roll driven while the splice head fires.
                next_acelerar = 1'b1;
                next_colar    = 1'b1;
            end
            CORTANDO:   next_cortar   = 1'b1;
            ERRO:       next_alarme   = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Helper terms
    // ------------------------------------------------------------------------
    assign timed_state    = (estado == ACELERANDO) ||
                            (estado == COLANDO)    ||
                            (estado == CORTANDO);
    assign entering_troca = (next_estado == TROCA_EFETUADA) && (estado != TROCA_EFETUADA);
    assign entering_erro  = (next_estado == ERRO)           && (estado != ERRO);

    // ------------------------------------------------------------------------
    // State, phase counter and registered actuators
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            // Reset drops every actuator at once, even in the middle of a cut.
            estado   <= STAND_BY;
            cnt      <= '0;
            acelerar <= 1'b0;
            colar    <= 1'b0;
            cortar   <= 1'b0;
            alarme   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples pre-edge values.
            estado   <= next_estado;
            acelerar <= next_acelerar;
            colar    <= next_colar;
            cortar   <= next_cortar;
            alarme   <= next_alarme;

            // Each phase starts counting from zero. The counter runs only in
            // timed states, and each of those leaves before it can overflow.
            if (next_estado != estado)
                cnt <= '0;
            else if (timed_state)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Event counters (saturating, counted on state entry)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            trocas <= '0;
            erros  <= '0;
        end else begin
            if (entering_troca && (trocas != CNT_SAT))
                trocas <= trocas + NBITS_CNT'(1);
            if (entering_erro && (erros != CNT_SAT))
                erros <= erros + NBITS_CNT'(1);
        end
    end

endmodule

// File: tb/tb_bobina_troca_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bobina_troca_ctrl
//
// Directed bench for bobina_troca_ctrl. Each step drives the sensors and
// pushes the expected post-edge outputs onto a scoreboard. One clk_2 edge
// later it pops that entry and compares it with the DUT. A small entry model
// keeps the expected trocas / erros counts, including saturation.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bobina_troca_ctrl;

    logic       clk_2;
    logic       reset;
    logic       nova;
    logic       velocidade;
    logic       vazio;
    logic       ack;
    logic       acelerar;
    logic       colar;
    logic       cortar;
    logic       alarme;
    logic [2:0] estado;
    logic [7:0] trocas;
    logic [7:0] erros;

    bobina_troca_ctrl #(
        .T_ACEL_MAX (16),
        .T_COLA     (4),
        .T_CORTE    (2),
        .NBITS_CNT  (8)
    ) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .nova       (nova),
        .velocidade (velocidade),
        .vazio      (vazio),
        .ack        (ack),
        .acelerar   (acelerar),
        .colar      (colar),
        .cortar     (cortar),
        .alarme     (alarme),
        .estado     (estado),
        .trocas     (trocas),
        .erros      (erros)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // Packed expectation: {estado[2:0], acelerar, colar, cortar, alarme, trocas[7:0], erros[7:0]}
    typedef struct {
        string       tag;
        logic [22:0] val;
    } exp_t;

    exp_t sb[$];

    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] prev_st  = 3'd0;
    logic [7:0] trocas_m = 8'd0;
    logic [7:0] erros_m  = 8'd0;

    // Expected-value side: count on entry to TROCA_EFETUADA / ERRO, saturating at 255.
    task automatic push_exp(input string tag, input logic [2:0] st,
                            input logic ea, input logic ec, input logic ek, input logic eal);
        exp_t e;
        if (st == 3'd5 && prev_st != 3'd5 && trocas_m != 8'd255) trocas_m = trocas_m + 8'd1;
        if (st == 3'd1 && prev_st != 3'd1 && erros_m  != 8'd255) erros_m  = erros_m + 8'd1;
        prev_st = st;
        e.tag = tag;
        e.val = {st, ea, ec, ek, eal, trocas_m, erros_m};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [22:0] obs;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed no entry, expected one pending");
            return;
        end
        e   = sb.pop_front();
        obs = {estado, acelerar, colar, cortar, alarme, trocas, erros};
        assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed st=%0d a/c/k/al=%b tr=%0d er=%0d, expected st=%0d a/c/k/al=%b tr=%0d er=%0d",
                   e.tag, obs[22:20], obs[19:16], obs[15:8], obs[7:0],
                   e.val[22:20], e.val[19:16], e.val[15:8], e.val[7:0]);
        end
    endtask

    // Drive sensors, expect the given outputs after the next clk_2 edge.
    task automatic step(input logic n, input logic v, input logic vz, input logic a,
                        input logic [2:0] st, input logic ea, input logic ec,
                        input logic ek, input logic eal, input string tag);
        nova       = n;
        velocidade = v;
        vazio      = vz;
        ack        = a;
        push_exp(tag, st, ea, ec, ek, eal);
        @(posedge clk_2);
        #1;
        check_out();
    endtask

    // Assert reset asynchronously and check the outputs without a clock edge.
    task automatic reset_now(input string tag);
        reset    = 1'b0;
        trocas_m = 8'd0;
        erros_m  = 8'd0;
        prev_st  = 3'd0;
        push_exp(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_out();
    endtask

    // Shortest changeover (velocidade already matched), then withdraw nova.
    task automatic fast_swap(input string tag);
        step(1, 1, 0, 0, 3'd2, 1, 0, 0, 0, {tag, "_acel"});
        step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, {tag, "_cola"});
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, {tag, "_cola_hold"});
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, {tag, "_corte"});
        step(1, 0, 1, 0, 3'd4, 0, 0, 1, 0, {tag, "_corte_ignores"});
        step(1, 0, 1, 0, 3'd5, 0, 0, 0, 0, {tag, "_troca"});
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, {tag, "_standby"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        nova       = 1'b0;
        velocidade = 1'b0;
        vazio      = 1'b0;
        ack        = 1'b0;
        #1;
        reset_now("reset_state");
        @(posedge clk_2);
        #1;
        reset = 1'b1;

        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "idle");

        // Nominal: velocidade on the 3rd ACELERANDO cycle.
        step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "nom_acel");
        step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "nom_acel_c1");
        step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "nom_acel_c2");
        step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "nom_cola");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "nom_cola_hold");
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, "nom_corte");
        step(1, 0, 1, 0, 3'd4, 0, 0, 1, 0, "nom_corte_ignores");
        step(1, 0, 0, 0, 3'd5, 0, 0, 0, 0, "nom_troca");
        step(1, 0, 0, 0, 3'd5, 0, 0, 0, 0, "nom_troca_hold");
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "nom_standby");

        // Acceleration timeout: 16 cycles in ACELERANDO, then ERRO.
        step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "to_acel");
        for (int i = 0; i < 15; i++)
            step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "to_acel_wait");
        step(1, 0, 0, 0, 3'd1, 0, 0, 0, 1, "to_erro");
        step(1, 0, 0, 0, 3'd1, 0, 0, 0, 1, "to_erro_hold");
        step(1, 0, 0, 1, 3'd1, 0, 0, 0, 1, "to_ack_nova_blocks");
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, "to_ack_clear");

        // Speed loss on the 2nd COLANDO cycle.
        step(1, 1, 0, 0, 3'd2, 1, 0, 0, 0, "sl_acel");
        step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "sl_cola");
        step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "sl_cola_c1");
        step(1, 0, 0, 0, 3'd1, 0, 0, 0, 1, "sl_erro");
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, "sl_clear");

        // Simultaneous inputs resolve by priority.
        step(1, 0, 1, 0, 3'd2, 1, 0, 0, 0, "sim_nova_over_vazio");
        step(1, 1, 1, 0, 3'd3, 1, 1, 0, 0, "sim_vel_over_vazio");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "sim_cola_hold");
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, "sim_corte");
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, "sim_corte_c1");
        step(1, 1, 0, 0, 3'd5, 0, 0, 0, 0, "sim_troca");
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "sim_standby");

        // Other fault paths and roll withdrawal.
        step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "wd_acel");
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "wd_withdrawn");
        step(0, 0, 1, 0, 3'd1, 0, 0, 0, 1, "sb_vazio_erro");
        step(0, 0, 1, 1, 3'd1, 0, 0, 0, 1, "sb_ack_vazio_blocks");
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, "sb_ack_clear");
        step(1, 0, 0, 0, 3'd2, 1, 0, 0, 0, "av_acel");
        step(1, 0, 1, 0, 3'd1, 0, 0, 0, 1, "av_vazio_erro");
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 0, "av_clear");

        // Reset in the middle of a cut, then a fresh changeover with nova held.
        step(1, 1, 0, 0, 3'd2, 1, 0, 0, 0, "rc_acel");
        step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "rc_cola");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "rc_cola_hold");
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, "rc_corte");
        reset_now("rc_reset_mid_cut");
        @(posedge clk_2);
        #1;
        reset = 1'b1;
        step(1, 1, 0, 0, 3'd2, 1, 0, 0, 0, "rc_restart_acel");
        step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "rc_restart_cola");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 3'd3, 1, 1, 0, 0, "rc_restart_cola_hold");
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, "rc_restart_corte");
        step(1, 1, 0, 0, 3'd4, 0, 0, 1, 0, "rc_restart_corte_c1");
        step(1, 1, 0, 0, 3'd5, 0, 0, 0, 0, "rc_restart_troca");
        step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, "rc_standby");

        // Saturation: run up to 255 changeovers, then one more.
        while (trocas_m != 8'd255)
            fast_swap("sat");
        fast_swap("sat_over");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
